// File: rtl/core_pkg.sv
// Shared core definitions: widths, well-known instruction encodings, fetch FSM states.
package core_pkg;
  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSN    = 32'h00000013;
  localparam logic [31:0] EBREAK_INSN = 32'h00100073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/if_id_register.sv
// Pipeline holding register (valid/pc/instr) with load, flush and drain-on-transfer.
module if_id_register
  import core_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] pc_in,
  input  logic [31:0]  instr_in,
  output logic         valid,
  output logic [W-1:0] pc,
  output logic [31:0]  instr
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSN;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end else if (valid && ready) begin
      // Consumer took the entry and nothing replaces it (e.g. fetch halted).
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// RV64 fetch stage: PC, RUN/HALT FSM, redirect/flush, IF/ID handshake toward decode.
// Optional macro IFETCH_MISALIGN_CHK_EN: misaligned redirect halts and flags fetch_misalign.
module instruction_fetch
  import core_pkg::*;
#(
  parameter int              XLEN      = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     HALT_INSN = EBREAK_INSN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_ready,
  output logic [XLEN-1:0] Inst_address,
  input  logic [31:0]     Instruction,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
`ifdef IFETCH_MISALIGN_CHK_EN
  output logic            fetch_misalign,
`endif
  output logic            halted
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load, ld_en, flush;

  assign load         = !if_id_valid || id_ready;
  assign Inst_address = pc_q;
  assign halted       = (state_q == HALT);

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign fetch_misalign = misalign_q;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ld_en   = 1'b0;
    flush   = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif
    if (branch_taken) begin
      flush = 1'b1;
`ifdef IFETCH_MISALIGN_CHK_EN
      if (branch_target[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        pc_d    = branch_target;
        state_d = RUN;
      end
`else
      pc_d    = branch_target & ~XLEN'(3);
      state_d = RUN;
`endif
    end else if (state_q == RUN && load) begin
      ld_en = 1'b1;
      // EBREAK is delivered but fetch parks on its address.
      if (Instruction == HALT_INSN) state_d = HALT;
      else                          pc_d    = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
`ifdef IFETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef IFETCH_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  if_id_register #(.W(XLEN)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (ld_en),
    .ready    (id_ready),
    .pc_in    (pc_q),
    .instr_in (Instruction),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .instr    (if_id_instr)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a 4-word combinational memory image.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset, branch_taken, id_ready;
  logic [63:0] branch_target, Inst_address, if_id_pc;
  logic [31:0] Instruction, if_id_instr;
  logic        if_id_valid, halted;
  int          checks = 0;
  int          errors = 0;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  always_comb begin
    case (Inst_address)
      64'd0:   Instruction = 32'h003100b3;
      64'd4:   Instruction = 32'h00308133;
      64'd8:   Instruction = 32'h00108193;
      64'd12:  Instruction = 32'h00100073;
      default: Instruction = 32'h00000013;
    endcase
  end

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_ready      (id_ready),
    .Inst_address  (Inst_address),
    .Instruction   (Instruction),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
`ifdef IFETCH_MISALIGN_CHK_EN
    .fetch_misalign(fetch_misalign),
`endif
    .halted        (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // valid, pc, instr, halted, fetch address
  task automatic chk_all(input string tag, input logic v, input logic [63:0] pc,
                         input logic [31:0] ins, input logic h, input logic [63:0] addr);
    chk({tag, ".valid"},  64'(if_id_valid), 64'(v));
    if (v) begin
      chk({tag, ".pc"},    if_id_pc, pc);
      chk({tag, ".instr"}, 64'(if_id_instr), 64'(ins));
    end
    chk({tag, ".halted"}, 64'(halted), 64'(h));
    chk({tag, ".addr"},   Inst_address, addr);
  endtask

  initial begin
    reset = 1'b0; branch_taken = 1'b0; branch_target = '0; id_ready = 1'b1;
    step(); step();
    chk("rst.valid",  64'(if_id_valid), 64'd0);
    chk("rst.pc",     if_id_pc, 64'd0);
    chk("rst.instr",  64'(if_id_instr), 64'h13);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.addr",   Inst_address, 64'd0);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("rst.mis",    64'(fetch_misalign), 64'd0);
`endif

    // Streaming to EBREAK
    reset = 1'b1;
    step(); chk_all("s0", 1, 0,  32'h003100b3, 0, 4);
    step(); chk_all("s1", 1, 4,  32'h00308133, 0, 8);
    step(); chk_all("s2", 1, 8,  32'h00108193, 0, 12);
    step(); chk_all("s3", 1, 12, 32'h00100073, 1, 12);
    step(); chk_all("h0", 0, 0,  0,            1, 12);
    step(); chk_all("h1", 0, 0,  0,            1, 12);

    // Redirect out of HALT
    branch_taken = 1'b1; branch_target = 64'd4;
    step(); chk_all("rh0", 0, 0, 0, 0, 4);
    branch_taken = 1'b0;
    step(); chk_all("rh1", 1, 4, 32'h00308133, 0, 8);

    // Decode back-pressure
    id_ready = 1'b0;
    step(); chk_all("st0", 1, 4, 32'h00308133, 0, 8);
    step(); chk_all("st1", 1, 4, 32'h00308133, 0, 8);
    step(); chk_all("st2", 1, 4, 32'h00308133, 0, 8);
    id_ready = 1'b1;
    step(); chk_all("st3", 1, 8, 32'h00108193, 0, 12);

    // Flush while stalled with a live entry
    id_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'd0;
    step(); chk_all("fl0", 0, 0, 0, 0, 0);
    branch_taken = 1'b0;
    step(); chk_all("fl1", 1, 0, 32'h003100b3, 0, 4);
    id_ready = 1'b1;

    // Misaligned target
    branch_taken = 1'b1; branch_target = 64'd6;
    step();
`ifdef IFETCH_MISALIGN_CHK_EN
    chk_all("mis0", 0, 0, 0, 1, 4);
    chk("mis0.flag", 64'(fetch_misalign), 64'd1);
    branch_taken = 1'b0;
    step(); chk_all("mis1", 0, 0, 0, 1, 4);
`else
    chk_all("mis0", 0, 0, 0, 0, 4);
    branch_taken = 1'b0;
    step(); chk_all("mis1", 1, 4, 32'h00308133, 0, 8);
`endif

    // PC wrap at top of address space
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); chk_all("wr0", 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    branch_taken = 1'b0;
    step(); chk_all("wr1", 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h13, 0, 0);

    // Halted with a stalled entry, then reset
    branch_taken = 1'b1; branch_target = 64'd12;
    step(); chk_all("hs0", 0, 0, 0, 0, 12);
    branch_taken = 1'b0; id_ready = 1'b0;
    step(); chk_all("hs1", 1, 12, 32'h00100073, 1, 12);
    step(); chk_all("hs2", 1, 12, 32'h00100073, 1, 12);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("hs2.mis", 64'(fetch_misalign), 64'd1);
`endif
    reset = 1'b0;
    step();
    chk("rr.valid",  64'(if_id_valid), 64'd0);
    chk("rr.pc",     if_id_pc, 64'd0);
    chk("rr.instr",  64'(if_id_instr), 64'h13);
    chk("rr.halted", 64'(halted), 64'd0);
    chk("rr.addr",   Inst_address, 64'd0);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("rr.mis",    64'(fetch_misalign), 64'd0);
`endif
    reset = 1'b1; id_ready = 1'b1;
    step(); chk_all("rr1", 1, 0, 32'h003100b3, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined RV64 core. Owns the program counter and drives the address into the combinational instruction memory. Captures the returned word into the IF/ID pipeline register with a valid/ready handshake toward decode. Handles branch redirect and flush, decode back-pressure, and a halt on EBREAK.

## Interface
- `XLEN`, 64, PC/address width
- `RESET_PC`, 64'h0, PC value loaded at reset
- `HALT_INSN`, 32'h00100073, encoding that stops fetch (EBREAK)

Ports:
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, synchronous, active-low
- `branch_taken` in 1, redirect request from EX; also flushes IF/ID
- `branch_target` in XLEN, redirect PC, sampled when `branch_taken`=1
- `id_ready` in 1, decode can accept IF/ID contents this cycle
- `Inst_address` out XLEN, fetch address to instruction memory, equals PC combinationally
- `Instruction` in 32, word returned by instruction memory in the same cycle
- `if_id_valid` out 1, IF/ID holds a live instruction
- `if_id_pc` out XLEN, PC of the held instruction
- `if_id_instr` out 32, held instruction word
- `halted` out 1, fetch stopped in HALT
- `fetch_misalign` out 1, present only with `IFETCH_MISALIGN_CHK_EN`

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values: PC=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=32'h00000013 (NOP), `halted`=0, `fetch_misalign`=0.
- Load condition `load = !if_id_valid || id_ready`. A transfer to decode occurs when `if_id_valid && id_ready`.
- Action priority, per cycle:
  1. **Redirect.** `branch_taken`=1 in any state: PC←target, `if_id_valid`←0, state→RUN. This discards the current fetch and the held IF/ID entry, and wins over stall and halt.
  2. **Load in RUN.** RUN and `load`: IF/ID←{PC, `Instruction`, valid=1}, PC←PC+4.
  3. **Halt entry.** If the loaded word equals `HALT_INSN`, it is still delivered valid, PC does not advance, and state→HALT.
  4. **Stall.** RUN and !`load`: PC and IF/ID hold.
- HALT:
  - PC frozen, no new loads.
  - `if_id_valid` clears once the held entry transfers.
  - `halted`=1.
  - Only reset or redirect leaves HALT, since an older branch may flush the EBREAK.
- Arithmetic:
  - PC+4 wraps modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC → 0.
  - Without the macro, the target is used as {target[XLEN-1:2], 2'b00}.
- Reset asserted mid-stall or mid-HALT: all state returns to reset values next edge. There is no pending redirect memory.

## Timing
- `Inst_address` is combinational from the PC register. Memory read is zero-latency. The instruction appears on the IF/ID outputs one edge after its address is driven.
- Redirect penalty: the edge with `branch_taken` produces a bubble (`if_id_valid`=0). The target instruction is valid one edge later.
- Steady state with `id_ready`=1: one instruction per cycle, PCs 0,4,8,...
- `id_ready` is sampled combinationally. There is no combinational path from `id_ready` or `branch_taken` to `Inst_address`.
- `halted` rises on the edge that captures `HALT_INSN`.

## Configuration
- `IFETCH_MISALIGN_CHK_EN` defined:
  - `branch_taken` with target[1:0]≠0 does not redirect.
  - It flushes IF/ID, enters HALT, and sets `fetch_misalign`=1, sticky until reset.
- Undefined: the port is absent and target bits [1:0] are forced to 0.

## Structure
- Shared package `core_pkg`:
  - `XLEN`
  - `NOP_INSN` (32'h00000013)
  - `EBREAK_INSN` (32'h00100073)
  - fetch state encoding (RUN=1'b0, HALT=1'b1)
- One sub-module, `if_id_register`: the valid/PC/instr holding register with load and flush inputs, reusable for the ID/EX boundary. PC logic and FSM stay in the top.

## Test plan
Memory image for all scenarios: 0:003100b3, 4:00308133, 8:00108193, 12:00100073.
- Reset released, `id_ready`=1 → `if_id_instr` sequence 003100b3, 00308133, 00108193, 00100073 on consecutive edges with `if_id_pc` 0,4,8,12. `halted`=1 after the fourth; PC stays 12.
- `id_ready`=0 for 3 cycles while holding PC 4 → IF/ID stays {4, 00308133}, `Inst_address` stays 8, then resumes with {8, 00108193}.
- `branch_taken`=1, target=0 while `id_ready`=0 and `if_id_valid`=1 → next edge `if_id_valid`=0, `Inst_address`=0. Following edge {0, 003100b3}.
- In HALT, `branch_taken`=1, target=4 → `halted`=0, next valid {4, 00308133}.
- With the macro, target=6 → `fetch_misalign`=1, `halted`=1, `if_id_valid`=0. Without the macro, target=6 → fetch from 4.
- Reset asserted while halted and stalled → all outputs at reset values next edge, `Inst_address`=0.
